// File: rtl/riscv_pkg.sv
// Shared stack-unit definitions: status encodings driven by the stack-unit FSM
// and the register save/restore sequencer state codes.
// Imported by the sequencer and by the stack-unit arbiter.
package riscv_pkg;

  // Stack-unit FSM status encodings (values 5..7 all mean "aborting")
  localparam logic [2:0] SU_IDLE       = 3'd0;
  localparam logic [2:0] SU_STACKING   = 3'd1;
  localparam logic [2:0] SU_PENDING    = 3'd2;
  localparam logic [2:0] SU_PREEMPTION = 3'd3;
  localparam logic [2:0] SU_UNSTACKING = 3'd4;
  localparam logic [2:0] SU_ABORT_MIN  = 3'd5;

  // Sequencer states
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_STORE      = 3'd1;
  localparam logic [2:0] S_STORE_WAIT = 3'd2;
  localparam logic [2:0] S_LOAD       = 3'd3;
  localparam logic [2:0] S_LOAD_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

endpackage

// File: rtl/riscv_su_sequencer.sv
// Saves/restores a NUM_REGS register frame to/from the stack, one request at a time.
// Latency: first request the cycle after STACKING/UNSTACKING is seen; done pulse one cycle after the last step.
// Backpressure: request held stable until i_req_ready; loads (and stores with RISCV_SU_SEQ_BRESP_EN) wait for i_rsp_valid.
module riscv_su_sequencer
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS     = 8,
  parameter int SU_FSM_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        enable,
  input  logic [SU_FSM_WIDTH-1:0]     i_fsm_status,
  input  logic [ADDR_WIDTH-1:0]       i_sp,
  output logic                        o_req_valid,
  output logic                        o_req_we,
  output logic [ADDR_WIDTH-1:0]       o_req_addr,
  output logic [$clog2(NUM_REGS)-1:0] o_req_idx,
  input  logic                        i_req_ready,
  input  logic                        i_rsp_valid,
  output logic                        o_all_in_stacked,
  output logic                        o_all_unstacked,
  output logic [ADDR_WIDTH-1:0]       o_sp
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] FRAME      = ADDR_WIDTH'(NUM_REGS * (DATA_WIDTH / 8));
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [SU_FSM_WIDTH-1:0] ST_STACK = SU_FSM_WIDTH'(SU_STACKING);
  localparam logic [SU_FSM_WIDTH-1:0] ST_UNSTK = SU_FSM_WIDTH'(SU_UNSTACKING);
  localparam logic [SU_FSM_WIDTH-1:0] ST_ABORT = SU_FSM_WIDTH'(SU_ABORT_MIN);

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic                  stacked_q, stacked_d;
  logic                  unstacked_q, unstacked_d;
  logic                  abort;
  logic                  req_hs;

  assign abort = (i_fsm_status >= ST_ABORT);

  // Request outputs; abort kills valid combinationally in the same cycle
  assign o_req_valid      = ((state_q == S_STORE) || (state_q == S_LOAD)) && !abort;
  assign o_req_we         = (state_q == S_STORE);
  assign o_req_idx        = idx_q;
  assign o_req_addr       = base_q + ADDR_WIDTH'(idx_q) * STRIDE;
  assign o_all_in_stacked = stacked_q;
  assign o_all_unstacked  = unstacked_q;
  assign o_sp             = sp_q;

  // Handshakes only count while the sequencer is allowed to advance
  assign req_hs = enable && o_req_valid && i_req_ready;

  // Next-state: frame sequencing, index/base counters and done pulses
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    sp_d        = sp_q;
    stacked_d   = 1'b0;
    unstacked_d = 1'b0;
    if (enable) begin
      if (abort) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_fsm_status == ST_STACK) begin
              base_d  = i_sp - FRAME;
              idx_d   = '0;
              state_d = S_STORE;
            end else if (i_fsm_status == ST_UNSTK) begin
              base_d  = sp_q;
              idx_d   = '0;
              state_d = S_LOAD;
            end
          end
`ifdef RISCV_SU_SEQ_BRESP_EN
          S_STORE: begin
            if (req_hs) state_d = S_STORE_WAIT;
          end
          S_STORE_WAIT: begin
            if (i_rsp_valid) begin
              if (idx_q == LAST_IDX) begin
                stacked_d = 1'b1;
                sp_d      = base_q;
                state_d   = S_DONE;
              end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_STORE;
              end
            end
          end
`else
          S_STORE: begin
            if (req_hs) begin
              if (idx_q == LAST_IDX) begin
                stacked_d = 1'b1;
                sp_d      = base_q;
                state_d   = S_DONE;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
`endif
          S_LOAD: begin
            if (req_hs) state_d = S_LOAD_WAIT;
          end
          S_LOAD_WAIT: begin
            if (i_rsp_valid) begin
              if (idx_q == LAST_IDX) begin
                unstacked_d = 1'b1;
                sp_d        = base_q + FRAME;
                state_d     = S_DONE;
              end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_LOAD;
              end
            end
          end
          S_DONE: begin
            // Hold until the stack unit moves on, so a re-entered STACKING nests a new frame
            if ((i_fsm_status != ST_STACK) && (i_fsm_status != ST_UNSTK)) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      sp_q        <= '0;
      stacked_q   <= 1'b0;
      unstacked_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      sp_q        <= sp_d;
      stacked_q   <= stacked_d;
      unstacked_q <= unstacked_d;
    end
  end

endmodule

// File: tb/tb_riscv_su_sequencer.sv
// Scoreboard bench for riscv_su_sequencer: stimulus pushes expected requests and
// done pulses into a queue, a negedge monitor pops and compares on each event.
// Works with or without RISCV_SU_SEQ_BRESP_EN defined.
module tb_riscv_su_sequencer;

  localparam int AW = 64;
  localparam int IW = 3;

  logic          clk;
  logic          nreset;
  logic          enable;
  logic [2:0]    i_fsm_status;
  logic [AW-1:0] i_sp;
  logic          o_req_valid;
  logic          o_req_we;
  logic [AW-1:0] o_req_addr;
  logic [IW-1:0] o_req_idx;
  logic          i_req_ready;
  logic          i_rsp_valid;
  logic          o_all_in_stacked;
  logic          o_all_unstacked;
  logic [AW-1:0] o_sp;

  riscv_su_sequencer #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .NUM_REGS(8), .SU_FSM_WIDTH(3)
  ) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .i_fsm_status(i_fsm_status),
    .i_sp(i_sp), .o_req_valid(o_req_valid), .o_req_we(o_req_we),
    .o_req_addr(o_req_addr), .o_req_idx(o_req_idx), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .o_all_in_stacked(o_all_in_stacked),
    .o_all_unstacked(o_all_unstacked), .o_sp(o_sp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // kind: 0 = request, 1 = stacked pulse, 2 = unstacked pulse
  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic        we;
    logic [2:0]  idx;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   hs_count = 0;
  int   pulse_count = 0;
  int   cyc = 0;
  int   last_hs = 0;
  bit   gap_chk = 0;
  bit   gap_armed = 0;
  bit   rsp_auto = 1;
  bit   rsp_kick = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int kind, input logic [63:0] base);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.kind = 0; e.addr = base + 64'(i * 8); e.we = (kind == 1); e.idx = 3'(i);
      q.push_back(e);
    end
    e.kind = kind; e.addr = '0; e.we = 1'b0; e.idx = '0;
    q.push_back(e);
  endtask

  task automatic push_req(input logic [63:0] addr, input logic we, input int idx);
    exp_t e;
    e.kind = 0; e.addr = addr; e.we = we; e.idx = 3'(idx);
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int n);
    int b;
    b = 0;
    while (pulse_count < n && b < 300) begin
      tick(1);
      b++;
    end
    chk("pulse_wait", 64'(pulse_count), 64'(n));
  endtask

  task automatic wait_req(input int idx);
    int  b;
    bit  found;
    b = 0;
    found = 0;
    while (!found && b < 100) begin
      tick(1);
      if (o_req_valid && o_req_idx == 3'(idx)) found = 1;
      b++;
    end
    chk("req_wait", 64'(found), 64'd1);
  endtask

  // Memory responder: one-cycle response in the cycle after each accepted request
  initial begin
    bit arm;
    i_rsp_valid = 1'b0;
    forever begin
      @(negedge clk);
      arm = rsp_auto && enable && o_req_valid && i_req_ready;
      @(posedge clk);
      #1;
      i_rsp_valid = arm || rsp_kick;
    end
  end

  // Monitor: pops the scoreboard on every handshake and done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (enable && o_req_valid && i_req_ready) begin
        hs_count++;
        if (gap_chk) begin
          if (gap_armed) chk("load_gap", 64'(cyc - last_hs), 64'd2);
          gap_armed = 1;
        end else begin
          gap_armed = 0;
        end
        last_hs = cyc;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %h idx %0d expected none", o_req_addr, o_req_idx);
        end else begin
          e = q.pop_front();
          chk("req_kind", 64'd0, 64'(e.kind));
          chk("req_addr", o_req_addr, e.addr);
          chk("req_we", 64'(o_req_we), 64'(e.we));
          chk("req_idx", 64'(o_req_idx), 64'(e.idx));
        end
      end
      if (o_all_in_stacked || o_all_unstacked) begin
        pulse_count++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got stacked=%0b unstacked=%0b expected none",
                   o_all_in_stacked, o_all_unstacked);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", o_all_in_stacked ? 64'd1 : 64'd2, 64'(e.kind));
        end
      end
    end
  end

  initial begin
    nreset = 1'b0; enable = 1'b1; i_fsm_status = 3'd0; i_sp = '0; i_req_ready = 1'b0;
    #22;
    chk("rst_valid", 64'(o_req_valid), 64'd0);
    chk("rst_we", 64'(o_req_we), 64'd0);
    chk("rst_sp", o_sp, 64'd0);
    chk("rst_idx", 64'(o_req_idx), 64'd0);
    chk("rst_addr", o_req_addr, 64'd0);
    chk("rst_pulses", 64'({o_all_in_stacked, o_all_unstacked}), 64'd0);
    tick(1);
    nreset = 1'b1;
    tick(2);

    // Full store frame with ready held high
    i_req_ready = 1'b1; i_sp = 64'h1000;
    push_frame(1, 64'hFC0);
    i_fsm_status = 3'd1;
    wait_pulses(1);
    chk("sp_after_stack", o_sp, 64'hFC0);
    i_fsm_status = 3'd2;
    tick(2);

    // Full load frame, response one cycle after each accept: 2 cycles per register
    gap_chk = 1;
    push_frame(2, 64'hFC0);
    i_fsm_status = 3'd4;
    wait_pulses(2);
    chk("sp_after_unstack", o_sp, 64'h1000);
    gap_chk = 0;
    i_fsm_status = 3'd0;
    tick(2);

    // Ready stall mid-frame, then enable low with ready high
    i_sp = 64'h2000;
    push_frame(1, 64'h1FC0);
    i_fsm_status = 3'd1;
    wait_req(3);
    i_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall_valid", 64'(o_req_valid), 64'd1);
      chk("stall_addr", o_req_addr, 64'h1FD8);
      chk("stall_idx", 64'(o_req_idx), 64'd3);
    end
    begin
      int hs_before;
      hs_before = hs_count;
      enable = 1'b0; i_req_ready = 1'b1;
      tick(3);
      chk("frozen_valid", 64'(o_req_valid), 64'd1);
      chk("frozen_idx", 64'(o_req_idx), 64'd3);
      chk("frozen_no_hs", 64'(hs_count), 64'(hs_before));
      enable = 1'b1;
    end
    wait_pulses(3);
    chk("sp_after_stall", o_sp, 64'h1FC0);
    i_fsm_status = 3'd0;
    tick(2);

    // Abort at idx 3: valid drops in the same cycle, no pulse, o_sp kept
    i_sp = 64'h3000;
    push_req(64'h2FC0, 1'b1, 0);
    push_req(64'h2FC8, 1'b1, 1);
    push_req(64'h2FD0, 1'b1, 2);
    i_fsm_status = 3'd1;
    wait_req(3);
    i_fsm_status = 3'd5;
    @(negedge clk);
    chk("abort_valid_now", 64'(o_req_valid), 64'd0);
    chk("abort_idx_held", 64'(o_req_idx), 64'd3);
    tick(1);
    i_fsm_status = 3'd0;
    tick(3);
    chk("abort_idle_valid", 64'(o_req_valid), 64'd0);
    chk("abort_sp", o_sp, 64'h1FC0);
    chk("abort_no_pulse", 64'(pulse_count), 64'd3);

    // Nested frame: STACKING -> PENDING -> PREEMPTION -> STACKING
    i_sp = 64'h1000;
    push_frame(1, 64'hFC0);
    i_fsm_status = 3'd1;
    wait_pulses(4);
    i_fsm_status = 3'd2;
    tick(2);
    i_fsm_status = 3'd3;
    tick(2);
    i_sp = 64'hFC0;
    push_frame(1, 64'hF80);
    i_fsm_status = 3'd1;
    wait_pulses(5);
    chk("sp_nested", o_sp, 64'hF80);
    i_fsm_status = 3'd0;
    tick(2);

`ifdef RISCV_SU_SEQ_BRESP_EN
    // Store waits for its write response before the next request
    begin
      int hs_before;
      rsp_auto = 0;
      i_sp = 64'h5000;
      hs_before = hs_count;
      push_req(64'h4FC0, 1'b1, 0);
      i_fsm_status = 3'd1;
      tick(6);
      chk("bresp_one_hs", 64'(hs_count), 64'(hs_before + 1));
      chk("bresp_valid_low", 64'(o_req_valid), 64'd0);
      chk("bresp_idx0", 64'(o_req_idx), 64'd0);
      for (int i = 1; i < 8; i++) push_req(64'h4FC0 + 64'(i * 8), 1'b1, i);
      q.push_back('{kind: 1, addr: 64'd0, we: 1'b0, idx: 3'd0});
      rsp_kick = 1;
      tick(1);
      rsp_kick = 0;
      rsp_auto = 1;
      tick(1);
      wait_pulses(6);
      chk("sp_bresp", o_sp, 64'h4FC0);
      i_fsm_status = 3'd0;
      tick(2);
    end
`endif

    // Reset mid-frame drops the outstanding request asynchronously
    i_req_ready = 1'b0; i_sp = 64'h6000;
    i_fsm_status = 3'd1;
    tick(2);
    chk("pre_rst_valid", 64'(o_req_valid), 64'd1);
    chk("pre_rst_addr", o_req_addr, 64'h5FC0);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_req_valid), 64'd0);
    chk("mid_rst_sp", o_sp, 64'd0);
    chk("mid_rst_we", 64'(o_req_we), 64'd0);
    i_fsm_status = 3'd0;
    tick(2);
    nreset = 1'b1;
    tick(2);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_su_sequencer.md
RISCV_SU_SEQUENCER -- requirements
Module: riscv_su_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning the stack address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning the saved register width (byte stride = DATA_WIDTH/8).
REQ-003 SHALL have parameter NUM_REGS, default 8, meaning the registers per stack frame (>=2).
REQ-004 SHALL have parameter SU_FSM_WIDTH, default 3, meaning the width of the stack-unit status input.
REQ-005 SHALL have ports:
- clk  in  1  clock; one clock only.
- nreset  in  1  reset; asynchronous, active-low.
- enable  in  1  advance enable; low freezes all state.
- i_fsm_status  in  SU_FSM_WIDTH  stack-unit FSM state: 0 IDLE, 1 STACKING, 2 PENDING, 3 PREEMPTION, 4 UNSTACKING, 5-7 ABORTING.
- i_sp  in  ADDR_WIDTH  current stack pointer.
- o_req_valid  out  1  memory request valid.
- o_req_we  out  1  1 = store, 0 = load.
- o_req_addr  out  ADDR_WIDTH  request byte address.
- o_req_idx  out  $clog2(NUM_REGS)  register-file index being saved or restored.
- i_req_ready  in  1  request accepted.
- i_rsp_valid  in  1  load data returned, or write response.
- o_all_in_stacked  out  1  one-cycle pulse: frame fully stored.
- o_all_unstacked  out  1  one-cycle pulse: frame fully restored.
- o_sp  out  ADDR_WIDTH  stack pointer after the last completed frame operation.

Function
REQ-006 SHALL implement states S_IDLE, S_STORE, S_STORE_WAIT, S_LOAD, S_LOAD_WAIT and S_DONE.
REQ-007 SHALL, in S_IDLE, on i_fsm_status==1 latch base = i_sp - NUM_REGS*DATA_WIDTH/8 (modulo 2^ADDR_WIDTH), clear idx and enter S_STORE.
REQ-008 SHALL, in S_IDLE, on i_fsm_status==4 latch base = o_sp, clear idx and enter S_LOAD.
REQ-009 SHALL drive o_req_addr = base + idx*DATA_WIDTH/8 and o_req_idx = idx.
REQ-010 SHALL assert o_req_valid in S_STORE and S_LOAD only, and SHALL hold addr, we and idx stable until valid&ready.
REQ-011 SHALL keep exactly one request outstanding: on a load handshake go to S_LOAD_WAIT; on i_rsp_valid increment idx and return to S_LOAD, or go to S_DONE when idx==NUM_REGS-1.
REQ-012 SHALL treat a store handshake as complete per REQ-023/REQ-024.
REQ-013 SHALL, on store-frame completion, pulse o_all_in_stacked for exactly one cycle, set o_sp = base and enter S_DONE.
REQ-014 SHALL, on load-frame completion, pulse o_all_unstacked for exactly one cycle, set o_sp = base + NUM_REGS*DATA_WIDTH/8 and enter S_DONE.
REQ-015 SHALL leave S_DONE for S_IDLE when i_fsm_status no longer equals 1 or 4, so that a preemption re-entering STACKING starts a new nested frame below o_sp.
REQ-016 SHALL, whenever i_fsm_status is 5-7 in any state, deassert o_req_valid in the same cycle (combinational override), enter S_IDLE on the next edge, leave o_sp unchanged and emit no done pulse.
REQ-017 SHALL ignore i_rsp_valid outside the wait states.
REQ-018 SHALL, when enable is low, hold state, idx, base and o_sp; o_req_valid SHALL keep its value and handshakes SHALL be ignored.
REQ-019 SHALL, when ready and the response arrive in consecutive cycles, sustain a throughput of one register per 2 cycles for loads.

Reset
REQ-020 SHALL, while nreset is low, force S_IDLE, idx=0, base=0, o_sp=0, o_req_valid=0, o_req_we=0 and both done pulses to 0, asynchronously.
REQ-021 SHALL, on reset assertion mid-frame, drop the outstanding request with no completion.
REQ-022 SHALL resume with the first rising edge after nreset deasserts.

Configuration
REQ-023 SHALL, with macro RISCV_SU_SEQ_BRESP_EN defined, enter S_STORE_WAIT after each store handshake and advance only on i_rsp_valid.
REQ-024 SHALL, without RISCV_SU_SEQ_BRESP_EN, advance idx directly on the store handshake (one store per cycle at full ready) and omit S_STORE_WAIT.

Structure
REQ-025 SHALL place the stack-unit status encodings (0-7) and the sequencer state enum in riscv_pkg, shared with the stack-unit arbiter.
REQ-026 SHALL have no sub-module; the address/index counter SHALL be inline logic.

Verification
REQ-027 Bench: with NUM_REGS=8, i_sp=0x1000, status=1, ready held 1 -> 8 stores at 0xFC0..0xFF8 with idx 0..7 -> o_all_in_stacked pulse; o_sp=0xFC0.
REQ-028 Bench: status=4 after REQ-027 with rsp one cycle after each ready -> 8 loads at 0xFC0..0xFF8 -> o_all_unstacked pulse; o_sp=0x1000.
REQ-029 Bench: ready low for 5 cycles mid-frame -> valid, addr and idx remain stable throughout.
REQ-030 Bench: status=5 at idx=3 -> valid low in the same cycle, S_IDLE next cycle, no pulse, o_sp unchanged.
REQ-031 Bench: nested frame, STACKING->PENDING->PREEMPTION->STACKING with i_sp=0xFC0 -> second frame at 0xF80..0xFB8; o_sp=0xF80.
REQ-032 Bench: with RISCV_SU_SEQ_BRESP_EN defined, withhold rsp after store 0 -> idx stays 0 and no second request is issued until rsp.
